muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit in the execute stage, beside the ALU.
//   It takes the same rs1/rs2 operand buses (A, B) as the ALU.
//   It returns a 32-bit result to the same writeback mux.
//   The control unit holds the PC and register-file write while busy is high.
//   It samples the result on the single-cycle done pulse.

---
 rtl/muldiv_if.sv | 13 +
 rtl/muldiv_unit.sv | 75 +++++++
 tb/tb_muldiv_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: operand/control bundle between the execute stage and the mul/div unit
interface muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   modport master (output start, op, A, B, flush, input busy, done, result);
   modport slave  (input start, op, A, B, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift step per cycle on operand magnitudes
module muldiv_unit #(parameter int WIDTH = 32) (
   input logic     clk,
   input logic     rst_n,
   muldiv_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t             state, state_nx;
   logic [CW-1:0]      cnt;
   logic [2:0]         op_q;
   logic               neg, sa, sb, accept, special;
   logic [WIDTH-1:0]   m, res, ma, mb, special_val, div_val, fix_val;
   logic [2*WIDTH-1:0] acc, pn;
   logic [WIDTH:0]     mul_sum, trial;
   // operand decode: signedness by funct3, magnitudes, and the cases that finish at accept
   always_comb begin
      sa = ~(bus.op[0] & (bus.op[1] | bus.op[2])) & bus.A[WIDTH-1];
      sb = (bus.op[2] ? ~bus.op[0] : ~bus.op[1]) & bus.B[WIDTH-1];
      ma = sa ? -bus.A : bus.A;
      mb = sb ? -bus.B : bus.B;
      special = bus.op[2] & ((bus.B == '0) | (~bus.op[0] & (bus.A == MIN) & (&bus.B)));
      special_val = (bus.B == '0) ? (bus.op[1] ? bus.A : '1) : (bus.op[1] ? '0 : MIN);
      accept = bus.start & ((state == IDLE) | (state == DONE)) & ~bus.flush;
   end
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // next state: flush wins, then accept, then the iteration sequence
   always_comb begin
      state_nx = state;
      if (bus.flush) state_nx = IDLE;
      else if (accept) state_nx = special ? DONE : RUN;
      else if (state == RUN) state_nx = (cnt == CW'(WIDTH - 1)) ? FIX : RUN;
      else if (state == FIX) state_nx = DONE;
      else if (state == DONE) state_nx = IDLE;
   end
   // outputs decoded from state
   always_comb begin
      bus.busy = (state == RUN) | (state == FIX);
      bus.done = (state == DONE);
      bus.result = res;
   end
   // step arithmetic: multiply adds into the high half, divide trial-subtracts the divisor
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
      trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};
      pn = neg ? -acc : acc;
      div_val = op_q[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
      fix_val = op_q[2] ? (neg ? -div_val : div_val) : ((op_q[1:0] == 2'b00) ? pn[WIDTH-1:0] : pn[2*WIDTH-1:WIDTH]);
   end
   // datapath: acc holds {high, low} for multiply and {remainder, quotient} for divide
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         op_q <= '0;
         neg <= 1'b0;
         m <= '0;
         acc <= '0;
         res <= '0;
      end else if (accept) begin
         op_q <= bus.op;
         cnt <= '0;
         neg <= (bus.op[2] & bus.op[1]) ? sa : sa ^ sb;
         m <= bus.op[2] ? mb : ma;
         acc <= {{WIDTH{1'b0}}, bus.op[2] ? ma : mb};
         if (special) res <= special_val;
      end else if (!bus.flush && state == RUN) begin
         cnt <= cnt + 1'b1;
         acc <= op_q[2] ? (trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                        : {mul_sum, acc[WIDTH-1:1]};
      end else if (!bus.flush && state == FIX) res <= fix_val;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed ops against an arithmetic reference model
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   muldiv_if bus ();
   muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, q;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (o)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            q = sa / sb; p = q; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            q = sa % sb; p = q; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] exp;
      int lat, m, nb;
      exp = ref_md(o, a, b);
      lat = (o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 0 : 33;
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
      m = 0; nb = 0;
      while (!bus.done && m < 40) begin
         if (!bus.busy) nb++;
         @(posedge clk); #1;
         m++;
      end
      chk({tag, " latency"}, m, lat);
      chk({tag, " busy_gap"}, nb, 0);
      chk({tag, " result"}, bus.result, exp);
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, bus.done, 1'b0);
   endtask
   initial begin
      logic [31:0] prev, a, b;
      logic [2:0] o;
      int nd, sel;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
      #12;
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst result", bus.result, 0);
      @(negedge clk) rst_n = 1'b1;
      run_op(3'd0, 32'd7, 32'hFFFFFFFD, "mul");
      run_op(3'd1, 32'h80000000, 32'h80000000, "mulh");
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");
      run_op(3'd2, 32'hFFFFFFFF, 32'd2, "mulhsu");
      run_op(3'd4, 32'hFFFFFFF9, 32'd2, "div");
      run_op(3'd6, 32'hFFFFFFF9, 32'd2, "rem");
      run_op(3'd5, 32'd5, 32'd0, "divu0");
      run_op(3'd7, 32'd5, 32'd0, "remu0");
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
      for (int i = 0; i < 120; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'h0;
         if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         if (sel == 2) b = $urandom_range(1, 5);
         if (sel == 3) a = $urandom_range(0, 3);
         run_op(o, a, b, "rand");
      end
      run_op(3'd0, 32'd9, 32'd11, "pre_flush");
      prev = bus.result;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      nd = 0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         bus.start = (c == 10);
         bus.flush = (c == 20);
         if (c == 10) begin bus.op = 3'd3; bus.A = 32'h12345678; bus.B = 32'h9ABCDEF0; end
         @(posedge clk); #1;
         if (c == 10) chk("ignored start busy", bus.busy, 1);
         if (c == 20) begin
            chk("flush busy", bus.busy, 0);
            chk("flush done", bus.done, 0);
            chk("flush result", bus.result, prev);
         end
         if (c > 20 && bus.done) nd++;
      end
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush no_done", nd, 0);
      chk("flush result_held", bus.result, prev);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'd1000; bus.B = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("midrst busy", bus.busy, 0);
      chk("midrst done", bus.done, 0);
      chk("midrst result", bus.result, 0);
      @(negedge clk) rst_n = 1'b1;
      run_op(3'd5, 32'd100, 32'd7, "divu_after_rst");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
